// File: rtl/uart_pkg.sv
// Shared definitions for the buffered UART transmitter: the parity codes,
// the frame FSM encoding and a constant clog2 for sizing counters.
package uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result++;
        end
        return result;
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers and a registered head word that is
// valid whenever the FIFO is non-empty (first-word fall-through).
module uart_sync_fifo
    import uart_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [AW:0]      rd_ptr_next;
    logic             do_push;
    logic             do_pop;

    assign full        = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty       = (wr_ptr == rd_ptr);
    assign do_push     = push && !full;
    assign do_pop      = pop && !empty;
    assign rd_ptr_next = rd_ptr + (AW + 1)'(do_pop);

    // NOTE: the storage array has no reset; a flush only clears the pointers.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= wr_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            rd_data <= '0;
        end else begin
            wr_ptr <= wr_ptr + (AW + 1)'(do_push);
            rd_ptr <= rd_ptr_next;
            // A word written into an otherwise empty FIFO bypasses the array.
            if (do_push && (wr_ptr == rd_ptr_next)) begin
                rd_data <= wr_data;
            end else begin
                rd_data <= mem[rd_ptr_next[AW-1:0]];
            end
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter with configurable data bits, parity and stop bits;
// queued characters are sent back-to-back without idle gaps.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int BAUD_DIV   = 12,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 tx_start,
    input  logic [DATA_BITS-1:0] data_in,
    output logic                 tx,
    output logic                 tx_busy,
    output logic                 fifo_full,
    output logic                 overflow
);

    localparam int BW = clog2(BAUD_DIV) + 1;
    localparam int IW = clog2(DATA_BITS + 1);
    localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
    localparam logic [IW-1:0] DATA_LAST = IW'(DATA_BITS - 1);
    localparam logic [IW-1:0] STOP_LAST = IW'(STOP_BITS - 1);

    state_t               state;
    logic [BW-1:0]        baud_cnt;
    logic [IW-1:0]        bit_idx;
    logic [DATA_BITS-1:0] shift_reg;
    logic                 parity_bit;
    logic [DATA_BITS-1:0] fifo_data;
    logic                 fifo_empty;
    logic                 push_ok;
    logic                 frame_done;
    logic                 pop;

    assign push_ok    = tx_start && !fifo_full;
    assign frame_done = (state == ST_STOP) && (baud_cnt == '0) && (bit_idx == STOP_LAST);
    assign pop        = !fifo_empty && ((state == ST_IDLE) || frame_done);

    uart_sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (tx_start),
        .pop     (pop),
        .wr_data (data_in),
        .rd_data (fifo_data),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            baud_cnt   <= '0;
            bit_idx    <= '0;
            shift_reg  <= '0;
            parity_bit <= 1'b0;
            tx         <= 1'b1;
            tx_busy    <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            overflow <= tx_start && fifo_full;
            tx_busy  <= 1'b1;
            if (pop) begin
                // Loading from IDLE or straight out of the last stop bit.
                state      <= ST_START;
                tx         <= 1'b0;
                baud_cnt   <= BAUD_LAST;
                shift_reg  <= fifo_data;
                parity_bit <= (PARITY == PAR_ODD) ? ~^fifo_data : ^fifo_data;
            end else if (state == ST_IDLE) begin
                tx_busy <= push_ok;
            end else begin
                baud_cnt <= (baud_cnt == '0) ? BAUD_LAST : baud_cnt - BW'(1);
                if (baud_cnt == '0) begin
                    case (state)
                        ST_START: begin
                            state     <= ST_DATA;
                            tx        <= shift_reg[0];
                            shift_reg <= shift_reg >> 1;
                            bit_idx   <= '0;
                        end
                        ST_DATA: begin
                            if (bit_idx != DATA_LAST) begin
                                tx        <= shift_reg[0];
                                shift_reg <= shift_reg >> 1;
                                bit_idx   <= bit_idx + IW'(1);
                            end else if (PARITY != PAR_NONE) begin
                                state <= ST_PARITY;
                                tx    <= parity_bit;
                            end else begin
                                state   <= ST_STOP;
                                tx      <= 1'b1;
                                bit_idx <= '0;
                            end
                        end
                        ST_PARITY: begin
                            state   <= ST_STOP;
                            tx      <= 1'b1;
                            bit_idx <= '0;
                        end
                        ST_STOP: begin
                            if (bit_idx == STOP_LAST) begin
                                state   <= ST_IDLE;
                                tx_busy <= push_ok;
                            end else begin
                                bit_idx <= bit_idx + IW'(1);
                            end
                        end
                        default: state <= ST_IDLE;
                    endcase
                end
            end
        end
    end

endmodule
